// File: rtl/operand_bank.sv
// Operand bank: strobe-driven A/B/func registers, registered ALU result
// and a select-driven display register.
module operand_bank #(
  parameter int WIDTH   = 4,
  parameter int F_COUNT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_a,
  input  logic             dec_a,
  input  logic             inc_b,
  input  logic             dec_b,
  input  logic             inc_f,
  input  logic             dec_f,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       func,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [WIDTH-1:0] disp_val,
  output logic [2:0]       disp_sel,
  output logic             changed
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [2:0]       F_MAX = 3'(F_COUNT - 1);

  logic [5:0] strb, s1, s2, s3, ev;
  logic [2:0] sel_s1, sel_s2;

  logic [WIDTH-1:0] a_nx, b_nx;
  logic [2:0]       f_nx;
  logic             upd;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic [7:0]       f_ext;
  logic [WIDTH-1:0] dv_nx;
  logic [2:0]       ds_nx;

  assign strb = {dec_f, inc_f, dec_b, inc_b, dec_a, inc_a};
  assign ev   = s2 & ~s3;

  // Sync flops reset high so a strobe held across reset is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= '1;
      s2     <= '1;
      s3     <= '1;
      sel_s1 <= '0;
      sel_s2 <= '0;
    end else begin
      s1     <= strb;
      s2     <= s1;
      s3     <= s2;
      sel_s1 <= sel;
      sel_s2 <= sel_s1;
    end
  end

  always_comb begin
    a_nx = op_a;
    b_nx = op_b;
    f_nx = func;
    if (ev[0] && !ev[1]) a_nx = op_a + ONE;
    if (ev[1] && !ev[0]) a_nx = op_a - ONE;
    if (ev[2] && !ev[3]) b_nx = op_b + ONE;
    if (ev[3] && !ev[2]) b_nx = op_b - ONE;
    if (ev[4] && !ev[5])
      f_nx = (func == F_MAX) ? 3'd0 : func + 3'd1;
    if (ev[5] && !ev[4])
      f_nx = (func == 3'd0) ? F_MAX : func - 3'd1;
    upd = (a_nx != op_a) || (b_nx != op_b)
       || (f_nx != func);
  end

  always_comb begin
    sum   = {1'b0, op_a} + {1'b0, op_b};
    alu_r = '0;
    alu_c = 1'b0;
    unique case (func)
      3'd0: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      3'd1: begin
        alu_r = op_a - op_b;
        alu_c = (op_a < op_b);
      end
      3'd2: alu_r = op_a & op_b;
      3'd3: alu_r = op_a | op_b;
      3'd4: alu_r = op_a ^ op_b;
      3'd5: alu_r = ~op_a;
      3'd6: begin
        alu_r = {op_a[WIDTH-2:0], 1'b0};
        alu_c = op_a[WIDTH-1];
      end
      3'd7: begin
        alu_r = {1'b0, op_a[WIDTH-1:1]};
        alu_c = op_a[0];
      end
    endcase
  end

  always_comb begin
    f_ext = {5'd0, func};
    dv_nx = result;
    ds_nx = 3'b000;
    case (sel_s2)
      3'b001: begin
        dv_nx = op_a;
        ds_nx = 3'b001;
      end
      3'b010: begin
        dv_nx = op_b;
        ds_nx = 3'b010;
      end
      3'b100: begin
        dv_nx = f_ext[WIDTH-1:0];
        ds_nx = 3'b100;
      end
      default: begin
        dv_nx = result;
        ds_nx = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      func     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      disp_val <= '0;
      disp_sel <= '0;
      changed  <= 1'b0;
    end else begin
      op_a     <= a_nx;
      op_b     <= b_nx;
      func     <= f_nx;
      result   <= alu_r;
      carry    <= alu_c;
      disp_val <= dv_nx;
      disp_sel <= ds_nx;
      changed  <= upd;
    end
  end

endmodule

// File: tb/tb_operand_bank.sv
// Scoreboard bench for operand_bank: stimulus pushes expectations,
// a negedge monitor pops and compares on changed / display checks.
module tb_operand_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inc_a = 0, dec_a = 0, inc_b = 0, dec_b = 0;
  logic       inc_f = 0, dec_f = 0;
  logic [2:0] sel = 3'b000;

  logic [3:0] op_a, op_b, result, disp_val;
  logic [2:0] func, disp_sel;
  logic       carry, changed;

  logic [3:0] op_a6, op_b6, result6, disp_val6;
  logic [2:0] func6, disp_sel6;
  logic       carry6, changed6;

  always #5 clk = ~clk;

  operand_bank #(.WIDTH(4), .F_COUNT(8)) dut (
    .clock(clk), .reset(reset),
    .inc_a(inc_a), .dec_a(dec_a),
    .inc_b(inc_b), .dec_b(dec_b),
    .inc_f(inc_f), .dec_f(dec_f),
    .sel(sel),
    .op_a(op_a), .op_b(op_b), .func(func),
    .result(result), .carry(carry),
    .disp_val(disp_val), .disp_sel(disp_sel),
    .changed(changed)
  );

  operand_bank #(.WIDTH(4), .F_COUNT(6)) dut6 (
    .clock(clk), .reset(reset),
    .inc_a(inc_a), .dec_a(dec_a),
    .inc_b(inc_b), .dec_b(dec_b),
    .inc_f(inc_f), .dec_f(dec_f),
    .sel(sel),
    .op_a(op_a6), .op_b(op_b6), .func(func6),
    .result(result6), .carry(carry6),
    .disp_val(disp_val6), .disp_sel(disp_sel6),
    .changed(changed6)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
    logic [2:0] f6;
  } exp_t;

  typedef struct {
    logic [3:0] val;
    logic [2:0] dsel;
    logic [3:0] res;
    logic       c;
  } disp_t;

  exp_t  exp_q[$];
  disp_t dq[$];
  int    total = 0;
  int    bad = 0;
  int    n_changed = 0;
  bit    chk = 1'b0;

  logic [3:0] ma = 0, mb = 0;
  logic [2:0] mf = 0, mf6 = 0;

  always @(negedge clk) begin
    exp_t  e;
    disp_t d;
    if (changed) begin
      n_changed++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_changed a=%0d b=%0d f=%0d, required no pulse",
                 op_a, op_b, func);
      end else begin
        e = exp_q.pop_front();
        if (op_a !== e.a || op_b !== e.b || func !== e.f
            || func6 !== e.f6) begin
          bad++;
          $display("FAIL update got a=%0d b=%0d f=%0d f6=%0d, required a=%0d b=%0d f=%0d f6=%0d",
                   op_a, op_b, func, func6, e.a, e.b, e.f, e.f6);
        end
      end
    end
    if (chk) begin
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL disp_queue empty at check");
      end else begin
        d = dq.pop_front();
        if (disp_val !== d.val || disp_sel !== d.dsel
            || result !== d.res || carry !== d.c) begin
          bad++;
          $display("FAIL disp got val=%0d sel=%b res=%0d c=%b, required val=%0d sel=%b res=%0d c=%b",
                   disp_val, disp_sel, result, carry,
                   d.val, d.dsel, d.res, d.c);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // mask order: {dec_f, inc_f, dec_b, inc_b, dec_a, inc_a}
  task automatic pulse(input logic [5:0] m);
    exp_t e;
    logic chg;
    chg = 1'b0;
    if (m[0] ^ m[1]) begin
      ma  = m[0] ? ma + 4'd1 : ma - 4'd1;
      chg = 1'b1;
    end
    if (m[2] ^ m[3]) begin
      mb  = m[2] ? mb + 4'd1 : mb - 4'd1;
      chg = 1'b1;
    end
    if (m[4] ^ m[5]) begin
      if (m[4]) begin
        mf  = (mf == 3'd7) ? 3'd0 : mf + 3'd1;
        mf6 = (mf6 == 3'd5) ? 3'd0 : mf6 + 3'd1;
      end else begin
        mf  = (mf == 3'd0) ? 3'd7 : mf - 3'd1;
        mf6 = (mf6 == 3'd0) ? 3'd5 : mf6 - 3'd1;
      end
      chg = 1'b1;
    end
    if (chg) begin
      e.a = ma; e.b = mb; e.f = mf; e.f6 = mf6;
      exp_q.push_back(e);
    end
    {dec_f, inc_f, dec_b, inc_b, dec_a, inc_a} = m;
    tick(3);
    {dec_f, inc_f, dec_b, inc_b, dec_a, inc_a} = '0;
    tick(5);
  endtask

  task automatic disp_check(input logic [2:0] s, input logic [3:0] v,
                            input logic [2:0] ds, input logic [3:0] r,
                            input logic c);
    disp_t d;
    sel = s;
    tick(5);
    d.val = v; d.dsel = ds; d.res = r; d.c = c;
    dq.push_back(d);
    chk = 1'b1;
    tick(1);
    chk = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_q.delete();
    ma = 0; mb = 0; mf = 0; mf6 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_func", func, 0);
    check("rst_res_carry", {result, carry}, 0);
    check("rst_disp", {disp_val, disp_sel, changed}, 0);
    tick(1);

    // 16 inc_a pulses wrap A back to 0
    c0 = n_changed;
    for (int i = 0; i < 16; i++) pulse(6'b000001);
    check("inc_a_wrap", op_a, 0);
    check("inc_a_changed_cnt", n_changed - c0, 16);

    // func wrap both ways (F_COUNT=8 and 6)
    pulse(6'b100000);
    check("dec_f_wrap6", func6, 5);
    pulse(6'b010000);
    check("inc_f_wrap6", func6, 0);

    // simultaneous inc_b/dec_b cancels
    c0 = n_changed;
    pulse(6'b001100);
    check("cancel_changed", n_changed - c0, 0);
    check("cancel_op_b", op_b, 0);

    // A=9, B=12 with A and B stepped together
    for (int i = 0; i < 9; i++) pulse(6'b000101);
    for (int i = 0; i < 3; i++) pulse(6'b000100);
    disp_check(3'b011, 4'd5, 3'b000, 4'd5, 1'b1);
    pulse(6'b010000);
    disp_check(3'b011, 4'd13, 3'b000, 4'd13, 1'b1);
    for (int i = 0; i < 5; i++) pulse(6'b010000);
    disp_check(3'b011, 4'd2, 3'b000, 4'd2, 1'b1);

    // A=3, B=7, F=4 (xor: result 4, carry 0)
    for (int i = 0; i < 5; i++) pulse(6'b001010);
    pulse(6'b000010);
    for (int i = 0; i < 2; i++) pulse(6'b100000);
    disp_check(3'b001, 4'd3, 3'b001, 4'd4, 1'b0);
    disp_check(3'b010, 4'd7, 3'b010, 4'd4, 1'b0);
    disp_check(3'b100, 4'd4, 3'b100, 4'd4, 1'b0);
    disp_check(3'b011, 4'd4, 3'b000, 4'd4, 1'b0);

    // event in flight discarded by reset
    inc_b = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    inc_b = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    ma = 0; mb = 0; mf = 0; mf6 = 0;
    c0 = n_changed;
    tick(6);
    check("inflight_op_b", op_b, 0);
    check("inflight_changed", n_changed - c0, 0);

    // strobe held across reset release
    inc_a = 1'b1;
    do_reset();
    c0 = n_changed;
    tick(6);
    check("held_op_a", op_a, 0);
    check("held_changed", n_changed - c0, 0);
    inc_a = 1'b0;
    tick(4);
    pulse(6'b000001);
    check("held_then_pulse", op_a, 1);

    tick(10);
    check("scoreboard_drained", exp_q.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_bank.md
OPERAND_BANK -- requirements
Module: operand_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits (2..8).
REQ-002 SHALL have parameter F_COUNT, default 8, number of legal function codes (2..8).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have ports inc_a, dec_a, inc_b, dec_b, inc_f, dec_f  input  1 each  asynchronous per-operand up/down strobes, arbitrary pulse width.
REQ-006 SHALL have port sel  input  3  asynchronous one-hot view select: 001 A, 010 B, 100 F.
REQ-007 SHALL have port op_a  output  WIDTH  operand A register.
REQ-008 SHALL have port op_b  output  WIDTH  operand B register.
REQ-009 SHALL have port func  output  3  function code register.
REQ-010 SHALL have port result  output  WIDTH  registered ALU result.
REQ-011 SHALL have port carry  output  1  registered carry/borrow/shift-out bit.
REQ-012 SHALL have port disp_val  output  WIDTH  registered value for display.
REQ-013 SHALL have port disp_sel  output  3  registered one-hot of the shown item; 000 when showing result.
REQ-014 SHALL have port changed  output  1  one-cycle pulse on any operand/func update.

Function
REQ-015 SHALL pass each strobe through a 2-flop synchronizer plus a third history flop; an event SHALL be s2 & ~s3 (rising edge only).
REQ-016 SHALL update the target register on the second rising clock edge after the edge that first samples the strobe high; one event per strobe pulse regardless of width.
REQ-017 SHALL increment op_a/op_b modulo 2^WIDTH: all-ones + 1 -> 0; 0 - 1 -> all-ones.
REQ-018 SHALL step func within 0..F_COUNT-1: F_COUNT-1 + 1 -> 0; 0 - 1 -> F_COUNT-1.
REQ-019 SHALL leave a register unchanged when its inc and dec events occur in the same cycle.
REQ-020 SHALL process events for different registers in the same cycle independently and simultaneously.
REQ-021 SHALL compute result/carry from op_a, op_b, func and register them one cycle after any operand change.
REQ-022 SHALL implement func codes: 0 A+B (carry=carry-out); 1 A-B (carry=borrow, A<B); 2 A&B; 3 A|B; 4 A^B; 5 ~A; 6 A<<1 (carry=A msb); 7 A>>1 (carry=A lsb); carry=0 for codes 2..5.
REQ-023 SHALL synchronize sel through two flops; disp_val/disp_sel SHALL follow the synchronized sel one cycle later.
REQ-024 SHALL show op_a for 001, op_b for 010, zero-extended func for 100, and result with disp_sel=000 for any other sel value.
REQ-025 SHALL pulse changed for exactly one cycle, coincident with the cycle the updated register value first appears, for any event that alters a register (no pulse when REQ-019 cancels).

Reset
REQ-026 SHALL, while reset is high at a clock edge, clear op_a, op_b, func, result, carry, disp_val, disp_sel, changed and sel synchronizer to 0.
REQ-027 SHALL set all strobe synchronizer and history flops to 1 during reset, so a strobe held high across reset release produces no event until it goes low then high.
REQ-028 SHALL discard any event in flight when reset asserts mid-operation; no register update after reset.

Verification
REQ-029 SHALL verify: WIDTH=4, 16 inc_a pulses from reset -> op_a 1..15 then 0, changed pulsing 16 times.
REQ-030 SHALL verify: dec_f at func=0, F_COUNT=6 -> func=5; inc_f at 5 -> 0.
REQ-031 SHALL verify: inc_b and dec_b rising together -> op_b unchanged, no changed pulse.
REQ-032 SHALL verify: A=9, B=12, func=0 -> result=5, carry=1; func=1 -> result=13, carry=1; func=6 -> result=2, carry=1.
REQ-033 SHALL verify: sel 001/010/100/011 with A=3, B=7, F=4 -> disp_val 3/7/4/result, disp_sel 001/010/100/000.
REQ-034 SHALL verify: inc_a held high through reset release -> op_a stays 0; after low-then-high -> op_a=1.
